// File: rtl/sgn_sub_pipe.sv
// Two-stage pipelined signed subtractor with reg/imm operand selection,
// full-width and saturated differences, overflow and illegal-op flags.
module sgn_sub_pipe #(
   parameter int DATA_W = 16,
   parameter int IMM_W  = 6,
   parameter bit SAT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        ctrl,
   input  logic [DATA_W-1:0] in_d1,
   input  logic [DATA_W-1:0] in_d2,
   input  logic [IMM_W-1:0]  in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:0]   out_d,
   output logic [DATA_W-1:0] out_sat,
   output logic              out_ovf,
   output logic              out_err
);

   localparam int FW = DATA_W + 1;
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      OP_RR = 2'b00,
      OP_RI = 2'b01,
      OP_IR = 2'b10,
      OP_BAD = 2'b11
   } opSel_t;

   logic [FW-1:0]     w_d1Ext;
   logic [FW-1:0]     w_d2Ext;
   logic [FW-1:0]     w_immExt;
   logic [FW-1:0]     w_opA;
   logic [FW-1:0]     w_opB;
   logic              w_err;
   logic              w_s1Adv;
   logic              w_s2Adv;
   logic [FW-1:0]     w_diff;
   logic              w_ovf;
   logic [DATA_W-1:0] w_sat;

   logic              r_s1Valid;
   logic [FW-1:0]     r_s1A;
   logic [FW-1:0]     r_s1B;
   logic              r_s1Err;

   logic              r_s2Valid;
   logic [FW-1:0]     r_s2D;
   logic [DATA_W-1:0] r_s2Sat;
   logic              r_s2Ovf;
   logic              r_s2Err;

   assign w_d1Ext  = {in_d1[DATA_W-1], in_d1};
   assign w_d2Ext  = {in_d2[DATA_W-1], in_d2};
   assign w_immExt = {{(FW-IMM_W){in_imm[IMM_W-1]}}, in_imm};

   // Illegal selects force both operands to zero so the result fields come out clean.
   always_comb begin
      w_opA = '0;
      w_opB = '0;
      w_err = 1'b0;
      case (opSel_t'(ctrl))
         OP_RR: begin
            w_opA = w_d1Ext;
            w_opB = w_d2Ext;
         end
         OP_RI: begin
            w_opA = w_d1Ext;
            w_opB = w_immExt;
         end
         OP_IR: begin
            w_opA = w_immExt;
            w_opB = w_d2Ext;
         end
         default: w_err = 1'b1;
      endcase
   end

   assign w_s2Adv  = !r_s2Valid || out_ready;
   assign w_s1Adv  = !r_s1Valid || w_s2Adv;
   assign in_ready = w_s1Adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_s1A     <= '0;
         r_s1B     <= '0;
         r_s1Err   <= 1'b0;
      end else if (w_s1Adv) begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_s1A   <= w_opA;
            r_s1B   <= w_opB;
            r_s1Err <= w_err;
         end
      end
   end

   assign w_diff = r_s1A - r_s1B;
   assign w_ovf  = w_diff[DATA_W] != w_diff[DATA_W-1];

   // Clamp toward the sign of the true (full-width) result when it no longer fits.
   always_comb begin
      w_sat = w_diff[DATA_W-1:0];
      if (SAT_EN && w_ovf) begin
         w_sat = w_diff[DATA_W] ? SAT_MIN : SAT_MAX;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2Valid <= 1'b0;
         r_s2D     <= '0;
         r_s2Sat   <= '0;
         r_s2Ovf   <= 1'b0;
         r_s2Err   <= 1'b0;
      end else if (w_s2Adv) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2D   <= w_diff;
            r_s2Sat <= w_sat;
            r_s2Ovf <= w_ovf;
            r_s2Err <= r_s1Err;
         end
      end
   end

   assign out_valid = r_s2Valid;
   assign out_d     = r_s2D;
   assign out_sat   = r_s2Sat;
   assign out_ovf   = r_s2Ovf;
   assign out_err   = r_s2Err;

endmodule

// File: tb/tb_sgn_sub_pipe.sv
// Directed bench for sgn_sub_pipe: hand-computed results, a queue of expected
// outputs popped on each output transfer, plus stall/hold and ready checks.
module tb_sgn_sub_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ctrl;
   logic [15:0] in_d1;
   logic [15:0] in_d2;
   logic [5:0]  in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_d;
   logic [15:0] out_sat;
   logic        out_ovf;
   logic        out_err;

   typedef struct {
      logic [16:0] d;
      logic [15:0] sat;
      logic        ovf;
      logic        err;
   } expRec_t;

   expRec_t     expQ[$];
   int          errors = 0;
   int          checks = 0;
   logic        monEn = 1'b0;
   logic        prevStall = 1'b0;
   logic [35:0] heldOut;

   sgn_sub_pipe #(.DATA_W(16), .IMM_W(6), .SAT_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
      .in_d1(in_d1), .in_d2(in_d2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_d(out_d), .out_sat(out_sat), .out_ovf(out_ovf), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one request and holds it until accepted; leaves in_valid high for back-to-back use.
   task automatic applyStimulus(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                                input logic [5:0] im, input logic [16:0] eD, input logic [15:0] eS,
                                input logic eO, input logic eE);
      logic    acc;
      expRec_t r;
      in_valid = 1'b1;
      ctrl     = c;
      in_d1    = a;
      in_d2    = b;
      in_imm   = im;
      acc      = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
      end else begin
         r.d = eD; r.sat = eS; r.ovf = eO; r.err = eE;
         expQ.push_back(r);
      end
   endtask

   task automatic idleInputs();
      in_valid = 1'b0;
      ctrl     = 2'b00;
      in_d1    = 16'hDEAD;
      in_d2    = 16'hBEEF;
      in_imm   = 6'h15;
   endtask

   task automatic drain();
      int k = 0;
      while (expQ.size() > 0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      checkOutput("drain", expQ.size(), 32'd0);
   endtask

   // Output monitor: ready model, hold-during-stall, and ordered result comparison.
   always @(negedge clk) begin
      if (rst || !monEn) begin
         prevStall = 1'b0;
      end else begin
         checkOutput("inReady", {31'd0, in_ready},
                     {31'd0, !(expQ.size() == 2 && !out_ready)});
         if (prevStall) begin
            checkOutput("holdStable", {out_valid, out_err, out_ovf, out_sat, out_d}, heldOut);
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious", {31'd0, out_valid}, 32'd0);
            end else begin
               expRec_t r;
               r = expQ.pop_front();
               checkOutput("outD", {15'd0, out_d}, {15'd0, r.d});
               checkOutput("outSat", {16'd0, out_sat}, {16'd0, r.sat});
               checkOutput("outOvf", {31'd0, out_ovf}, {31'd0, r.ovf});
               checkOutput("outErr", {31'd0, out_err}, {31'd0, r.err});
            end
         end
         prevStall = out_valid && !out_ready;
         heldOut   = {out_valid, out_err, out_ovf, out_sat, out_d};
      end
   end

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      idleInputs();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstD", {15'd0, out_d}, 32'd0);
      checkOutput("rstSat", {16'd0, out_sat}, 32'd0);
      checkOutput("rstOvfErr", {30'd0, out_ovf, out_err}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
      monEn = 1'b1;

      // Positive overflow, plus exact latency of the first result.
      applyStimulus(2'b00, 16'h7FFF, 16'h8000, 6'h00, 17'h0FFFF, 16'h7FFF, 1'b1, 1'b0);
      idleInputs();
      @(negedge clk);
      checkOutput("latencyEarly", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("latencyOnTime", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      drain();

      applyStimulus(2'b01, 16'h0005, 16'h0000, 6'h3F, 17'h00006, 16'h0006, 1'b0, 1'b0);
      applyStimulus(2'b10, 16'h0000, 16'h0001, 6'h20, 17'h1FFDF, 16'hFFDF, 1'b0, 1'b0);
      applyStimulus(2'b00, 16'h8000, 16'h0001, 6'h00, 17'h17FFF, 16'h8000, 1'b1, 1'b0);
      idleInputs();
      drain();

      // Six-deep stream with the consumer stalled for three cycles.
      fork
         begin
            applyStimulus(2'b00, 16'h0010, 16'h0003, 6'h00, 17'h0000D, 16'h000D, 1'b0, 1'b0);
            applyStimulus(2'b01, 16'h0100, 16'h0000, 6'h05, 17'h000FB, 16'h00FB, 1'b0, 1'b0);
            applyStimulus(2'b10, 16'h0000, 16'h0020, 6'h1F, 17'h1FFFF, 16'hFFFF, 1'b0, 1'b0);
            applyStimulus(2'b00, 16'h8000, 16'h7FFF, 6'h00, 17'h10001, 16'h8000, 1'b1, 1'b0);
            applyStimulus(2'b00, 16'hFFFF, 16'hFFFF, 6'h00, 17'h00000, 16'h0000, 1'b0, 1'b0);
            applyStimulus(2'b01, 16'h7FFF, 16'h0000, 6'h20, 17'h0801F, 16'h7FFF, 1'b1, 1'b0);
            idleInputs();
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Illegal op between two legal neighbours.
      applyStimulus(2'b00, 16'h0003, 16'h0001, 6'h00, 17'h00002, 16'h0002, 1'b0, 1'b0);
      applyStimulus(2'b11, 16'h1234, 16'h0567, 6'h2A, 17'h00000, 16'h0000, 1'b0, 1'b1);
      applyStimulus(2'b10, 16'h0000, 16'h0003, 6'h01, 17'h1FFFE, 16'hFFFE, 1'b0, 1'b0);
      idleInputs();
      drain();

      // Fill both stages under stall, then reset mid-cycle.
      out_ready = 1'b0;
      applyStimulus(2'b00, 16'h0040, 16'h0001, 6'h00, 17'h0003F, 16'h003F, 1'b0, 1'b0);
      applyStimulus(2'b00, 16'h0050, 16'h0001, 6'h00, 17'h0004F, 16'h004F, 1'b0, 1'b0);
      idleInputs();
      @(posedge clk);
      #1;
      checkOutput("preRstValid", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstValid", {31'd0, out_valid}, 32'd0);
      checkOutput("midRstD", {15'd0, out_d}, 32'd0);
      expQ.delete();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(2'b01, 16'h0000, 16'h0000, 6'h01, 17'h1FFFF, 16'hFFFF, 1'b0, 1'b0);
      idleInputs();
      drain();
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
